// File: rtl/cartoon_edge_detect_if.sv
// Pixel stream bundle for the Sobel edge detector: RGB input stream with controls,
// and centre-pixel / edge-mask output stream.
interface cartoon_edge_detect_if;
  logic        en;
  logic        in_valid;
  logic        sof;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic [7:0]  thresh;
  logic        out_valid;
  logic [23:0] pix_out;
  logic [7:0]  edge_out;

  modport master (
    output en, in_valid, sof, r, g, b, thresh,
    input  out_valid, pix_out, edge_out
  );

  modport slave (
    input  en, in_valid, sof, r, g, b, thresh,
    output out_valid, pix_out, edge_out
  );
endinterface

// File: rtl/cartoon_edge_detect.sv
// Streaming 3x3 Sobel edge detector: two RGB line buffers feed a window, stage 2
// converts taps to gray, thresholds |gx|+|gy| and emits the centre pixel with an edge mask.
module cartoon_edge_detect #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input logic                  clk,
  input logic                  rst_n,
  cartoon_edge_detect_if.slave bus
);
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned PIX_W = 24;
  localparam int unsigned Y_W   = 8;
  localparam int unsigned SUM_W = 10;
  localparam int unsigned GRD_W = 11;
  localparam int unsigned MAG_W = 12;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_col_last;
  logic             w_row_last;
  logic [PIX_W-1:0] w_pix;
  logic [PIX_W-1:0] w_rd0;
  logic [PIX_W-1:0] w_rd1;

  logic [PIX_W-1:0] r_line0 [IMG_W];
  logic [PIX_W-1:0] r_line1 [IMG_W];
  logic [PIX_W-1:0] r_win   [3][3];
  logic             r_v1;
  logic             r_undef;
  logic             r_border;

  logic [Y_W-1:0]   w_y [3][3];
  logic [SUM_W-1:0] w_gx_p;
  logic [SUM_W-1:0] w_gx_n;
  logic [SUM_W-1:0] w_gy_p;
  logic [SUM_W-1:0] w_gy_n;
  logic [GRD_W-1:0] w_gx;
  logic [GRD_W-1:0] w_gy;
  logic [GRD_W-1:0] w_ax;
  logic [GRD_W-1:0] w_ay;
  logic [MAG_W-1:0] w_mag;
  logic             w_edge;

  logic             r_out_valid;
  logic [PIX_W-1:0] r_pix_out;
  logic [7:0]       r_edge_out;

  function automatic logic [Y_W-1:0] gray(input logic [PIX_W-1:0] p);
    logic [SUM_W-1:0] s;
    s = SUM_W'(p[23:16]) + SUM_W'({p[15:8], 1'b0}) + SUM_W'(p[7:0]);
    return s[SUM_W-1:2];
  endfunction

  // sof forces the current pixel to be the frame origin
  always_comb begin
    w_col      = bus.sof ? '0 : r_col;
    w_row      = bus.sof ? '0 : r_row;
    w_col_last = (w_col == COL_W'(IMG_W - 1));
    w_row_last = (w_row == ROW_W'(IMG_H - 1));
  end

  assign w_pix = {bus.r, bus.g, bus.b};
  assign w_rd0 = r_line0[w_col];
  assign w_rd1 = r_line1[w_col];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (bus.in_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : w_row + ROW_W'(1);
      end else begin
        r_col <= w_col + COL_W'(1);
        r_row <= w_row;
      end
    end
  end

  // Line RAMs are not reset; row/col classification masks stale contents
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      r_line0[w_col] <= w_pix;
      r_line1[w_col] <= r_line0[w_col];
    end
  end

  // Stage 1: window shift and classification of the completing pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_undef  <= 1'b0;
      r_border <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= w_rd1;
        r_win[1][2] <= w_rd0;
        r_win[2][2] <= w_pix;
        r_undef     <= (w_col == '0) || (w_row == '0);
        r_border    <= (w_col == COL_W'(1)) || (w_row == ROW_W'(1));
      end
    end
  end

  // Stage 2 combinational: gray taps, Sobel gradients, magnitude and threshold
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_y[i][j] = gray(r_win[i][j]);
      end
    end
    w_gx_p = SUM_W'(w_y[0][2]) + SUM_W'({w_y[1][2], 1'b0}) + SUM_W'(w_y[2][2]);
    w_gx_n = SUM_W'(w_y[0][0]) + SUM_W'({w_y[1][0], 1'b0}) + SUM_W'(w_y[2][0]);
    w_gy_p = SUM_W'(w_y[2][0]) + SUM_W'({w_y[2][1], 1'b0}) + SUM_W'(w_y[2][2]);
    w_gy_n = SUM_W'(w_y[0][0]) + SUM_W'({w_y[0][1], 1'b0}) + SUM_W'(w_y[0][2]);
    w_gx   = GRD_W'(w_gx_p) - GRD_W'(w_gx_n);
    w_gy   = GRD_W'(w_gy_p) - GRD_W'(w_gy_n);
    w_ax   = w_gx[GRD_W-1] ? GRD_W'(-w_gx) : w_gx;
    w_ay   = w_gy[GRD_W-1] ? GRD_W'(-w_gy) : w_gy;
    w_mag  = MAG_W'(w_ax) + MAG_W'(w_ay);
    w_edge = !r_undef && !r_border && bus.en && (w_mag > MAG_W'(bus.thresh));
  end

  // Stage 2 registers; data holds through idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_pix_out   <= '0;
      r_edge_out  <= '0;
    end else begin
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_pix_out  <= r_undef ? '0 : r_win[1][1];
        r_edge_out <= w_edge ? 8'hFF : 8'h00;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.pix_out   = r_pix_out;
  assign bus.edge_out  = r_edge_out;
endmodule

// File: tb/tb_cartoon_edge_detect.sv
// Bench for cartoon_edge_detect: directed and random frames checked against a
// frame-level Sobel model that tracks pixel coordinates and stored input images.
module tb_cartoon_edge_detect;
  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst_n;

  cartoon_edge_detect_if bus ();

  cartoon_edge_detect #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [23:0] img     [H][W];
  logic [23:0] rnd_img [H][W];
  logic [31:0] exp_q [$];
  int          m_col;
  int          m_row;
  logic        prev_v;
  int          n_out;
  int          n_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int gray(input logic [23:0] p);
    return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
  endfunction

  // Expected output for an accepted pixel, from the stored frame around its centre
  task automatic model_push(input logic s, input logic [23:0] p);
    int c, r, gx, gy, mag;
    int y [3][3];
    logic [23:0] pix;
    logic [7:0]  e;
    if (s) begin
      m_col = 0;
      m_row = 0;
    end
    c = m_col;
    r = m_row;
    img[r][c] = p;
    pix = '0;
    e   = 8'h00;
    if (c > 0 && r > 0) begin
      pix = img[r-1][c-1];
      if (c > 1 && r > 1) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            y[i][j] = gray(img[r-2+i][c-2+j]);
        gx  = (y[0][2] + 2*y[1][2] + y[2][2]) - (y[0][0] + 2*y[1][0] + y[2][0]);
        gy  = (y[2][0] + 2*y[2][1] + y[2][2]) - (y[0][0] + 2*y[0][1] + y[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (bus.en && mag > int'(bus.thresh)) e = 8'hFF;
      end
    end
    exp_q.push_back({pix, e});
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row++;
      if (m_row == H) m_row = 0;
    end
  endtask

  // One clock: drive at negedge, check just after posedge
  task automatic tick(input logic v, input logic s, input logic [23:0] p);
    logic [31:0] e;
    bus.in_valid = v;
    bus.sof      = s;
    {bus.r, bus.g, bus.b} = p;
    if (v) model_push(s, p);
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(prev_v));
    if (prev_v) begin
      e = exp_q.pop_front();
      chk("pix_out", 32'(bus.pix_out), 32'(e[31:8]));
      chk("edge_out", 32'(bus.edge_out), 32'(e[7:0]));
      n_out++;
      if (bus.edge_out == 8'hFF) n_edge++;
    end
    prev_v = v;
    @(negedge clk);
  endtask

  function automatic logic [23:0] pat_pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 24'h808080;
      1:       return (c < 4) ? 24'h000000 : 24'hFFFFFF;
      default: return rnd_img[r][c];
    endcase
  endfunction

  // gap: 0 continuous, 1 alternate idle, 2 random idle; idle cycles carry junk incl. sof
  task automatic run_frame(input int pat, input int gap, input bit use_sof, input int k0, input int npix);
    int r, c;
    for (int k = k0; k < k0 + npix; k++) begin
      r = (k / W) % H;
      c = k % W;
      tick(1'b1, (use_sof && k == k0) ? 1'b1 : 1'b0, pat_pix(pat, r, c));
      if (gap == 1) tick(1'b0, 1'($urandom), 24'($urandom));
      if (gap == 2) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++)
          tick(1'b0, 1'($urandom), 24'($urandom));
      end
    end
  endtask

  task automatic drain();
    tick(1'b0, 1'b0, 24'h0);
    tick(1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.in_valid = 1'b0;
    bus.sof = 1'b0;
    bus.r = '0;
    bus.g = '0;
    bus.b = '0;
    bus.thresh = '0;
    prev_v = 1'b0;
    m_col = 0;
    m_row = 0;
    n_out = 0;
    n_edge = 0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        rnd_img[i][j] = 24'($urandom);

    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_pix_out", 32'(bus.pix_out), 32'h0);
    chk("rst_edge_out", 32'(bus.edge_out), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Flat grey frame, threshold 0: mag 0 never exceeds it
    bus.thresh = 8'd0;
    n_out = 0; n_edge = 0;
    run_frame(0, 0, 1'b1, 0, W*H);
    drain();
    chk("flat_count", 32'(n_out), 32'(W*H));
    chk("flat_edges", 32'(n_edge), 32'h0);

    // Vertical step: centre cols 3,4 on rows 1..4 give mag 1020
    bus.thresh = 8'd100;
    n_out = 0; n_edge = 0;
    run_frame(1, 0, 1'b1, 0, W*H);
    drain();
    chk("step100_edges", 32'(n_edge), 32'd8);

    bus.thresh = 8'd255;
    n_out = 0; n_edge = 0;
    run_frame(1, 0, 1'b1, 0, W*H);
    drain();
    chk("step255_edges", 32'(n_edge), 32'd8);

    bus.en = 1'b0;
    n_out = 0; n_edge = 0;
    run_frame(1, 0, 1'b1, 0, W*H);
    drain();
    chk("step_en0_edges", 32'(n_edge), 32'h0);
    bus.en = 1'b1;

    // Random image, continuous then alternating in_valid
    bus.thresh = 8'($urandom_range(0, 255));
    run_frame(2, 0, 1'b1, 0, W*H);
    drain();
    n_out = 0;
    run_frame(2, 1, 1'b1, 0, W*H);
    drain();
    chk("toggle_count", 32'(n_out), 32'(W*H));

    // sof resync at col 5 of row 3
    run_frame(2, 0, 1'b1, 0, 3*W + 5);
    run_frame(2, 0, 1'b1, 0, W*H);
    drain();

    // Random gaps with random en/threshold per frame
    for (int f = 0; f < 4; f++) begin
      bus.en = 1'($urandom);
      bus.thresh = 8'($urandom);
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++)
          rnd_img[i][j] = 24'($urandom);
      run_frame(2, 2, 1'b1, 0, W*H);
      drain();
    end

    // Reset mid-frame while an edge pixel is on the outputs
    bus.en = 1'b1;
    bus.thresh = 8'd100;
    run_frame(1, 0, 1'b1, 0, 3*W + 7);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_pix_out", 32'(bus.pix_out), 32'h0);
    chk("midrst_edge_out", 32'(bus.edge_out), 32'h0);
    exp_q.delete();
    prev_v = 1'b0;
    m_col = 0;
    m_row = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_edge = 0;
    run_frame(1, 0, 1'b0, 0, W);
    chk("postrst_row0_edges", 32'(n_edge), 32'h0);
    run_frame(1, 0, 1'b0, W, W*H - W);
    drain();
    chk("postrst_edges", 32'(n_edge), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
